// File: rtl/gray_counter_param.sv
// gray_counter_param: parameterised up/down Gray-code counter.
//   A binary state B is kept internally; bin_out = B and gray_out = B ^ (B >> 1)
//   are both registered and updated on the same rising edge of clk.
//   Edge priority: rst, then load, then count. SATURATE selects wrap (0) or
//   hold (1) at the ends of the range. tc is combinational terminal count.
// Optional build macro: GRAY_STEP_CHECK_EN
//   When defined, a checker flags (sticky err) any Gray step of more than one
//   bit following a pure count/hold edge. When undefined, err is tied to 0.
module gray_counter_param #(
  parameter int unsigned WIDTH    = 4,
  parameter bit          SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clk_en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] gray_out,
  output logic [WIDTH-1:0] bin_out,
  output logic             tc,
  output logic             err
);

  localparam logic [WIDTH-1:0] MAX_VAL = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] MIN_VAL = {WIDTH{1'b0}};

  logic [WIDTH-1:0] r_bin;
  logic [WIDTH-1:0] r_gray;
  logic [WIDTH-1:0] w_bin_nxt;
  logic [WIDTH-1:0] w_gray_nxt;
  logic             w_at_top;
  logic             w_at_bot;
  logic             w_at_end;

  // End-of-range detection in the currently selected direction
  assign w_at_top = (r_bin == MAX_VAL);
  assign w_at_bot = (r_bin == MIN_VAL);
  assign w_at_end = up_dn ? w_at_top : w_at_bot;

  // Terminal count: only on a live count edge about to cross an end
  assign tc = clk_en & ~load & ~rst & w_at_end;

  // Next binary state: load beats count; wrap falls out of modulo arithmetic
  always_comb begin
    w_bin_nxt = r_bin;
    if (load) begin
      w_bin_nxt = load_val;
    end else if (clk_en) begin
      if (SATURATE && w_at_end) begin
        w_bin_nxt = r_bin;
      end else if (up_dn) begin
        w_bin_nxt = r_bin + WIDTH'(1);
      end else begin
        w_bin_nxt = r_bin - WIDTH'(1);
      end
    end
  end

  // Gray encoding of the next state so gray_out and bin_out update together
  assign w_gray_nxt = w_bin_nxt ^ (w_bin_nxt >> 1);

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      r_bin  <= MIN_VAL;
      r_gray <= MIN_VAL;
    end else begin
      r_bin  <= w_bin_nxt;
      r_gray <= w_gray_nxt;
    end
  end

  assign bin_out  = r_bin;
  assign gray_out = r_gray;

`ifdef GRAY_STEP_CHECK_EN
  logic [WIDTH-1:0] r_gray_prev;
  logic             r_prev_pure;
  logic             r_err;
  logic [WIDTH-1:0] w_diff;
  logic             w_multi_bit;

  // More than one bit differs iff clearing the lowest set bit leaves any bit set
  assign w_diff      = r_gray ^ r_gray_prev;
  assign w_multi_bit = |(w_diff & (w_diff - WIDTH'(1)));

  // Step checker: previous-value history plus sticky error flag
  always_ff @(posedge clk) begin
    if (rst) begin
      r_gray_prev <= MIN_VAL;
      r_prev_pure <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_gray_prev <= r_gray;
      r_prev_pure <= ~load;
      if (r_prev_pure && w_multi_bit) begin
        r_err <= 1'b1;
      end
    end
  end

  assign err = r_err;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_gray_counter_param.sv
// tb_gray_counter_param: randomized and directed checks of gray_counter_param
// (WIDTH=4) in both wrap and saturate builds against a behavioural model.
module tb_gray_counter_param;

  localparam int unsigned W    = 4;
  localparam int unsigned MAXV = 15;

  logic         clk;
  logic         rst;
  logic         clk_en;
  logic         up_dn;
  logic         load;
  logic [W-1:0] load_val;

  logic [W-1:0] gray_w, bin_w, gray_s, bin_s;
  logic         tc_w, err_w, tc_s, err_s;

  int n_chk  = 0;
  int n_pass = 0;

  int unsigned m_w = 0;
  int unsigned m_s = 0;
  bit          m_valid = 1'b0;
  bit          cmp_en  = 1'b1;

  gray_counter_param #(.WIDTH(W), .SATURATE(1'b0)) u_wrap (
    .clk(clk), .rst(rst), .clk_en(clk_en), .up_dn(up_dn), .load(load),
    .load_val(load_val), .gray_out(gray_w), .bin_out(bin_w), .tc(tc_w), .err(err_w)
  );

  gray_counter_param #(.WIDTH(W), .SATURATE(1'b1)) u_sat (
    .clk(clk), .rst(rst), .clk_en(clk_en), .up_dn(up_dn), .load(load),
    .load_val(load_val), .gray_out(gray_s), .bin_out(bin_s), .tc(tc_s), .err(err_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int unsigned to_gray(input int unsigned b);
    return b ^ (b >> 1);
  endfunction

  // One count step from the rules: +1/-1 modulo 16, or hold at an end if saturating
  function automatic int unsigned step(input int unsigned b, input bit up, input bit sat);
    bit at_end;
    at_end = up ? (b == MAXV) : (b == 0);
    if (sat && at_end) return b;
    return (b + (up ? 1 : MAXV)) % (MAXV + 1);
  endfunction

  function automatic bit tc_exp(input int unsigned b);
    if (rst || load || !clk_en) return 1'b0;
    return up_dn ? (b == MAXV) : (b == 0);
  endfunction

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Reference model advanced on each rising edge
  always @(posedge clk) begin
    if (rst) begin
      m_w = 0; m_s = 0; m_valid = 1'b1;
    end else if (load) begin
      m_w = load_val; m_s = load_val;
    end else if (clk_en) begin
      m_w = step(m_w, up_dn, 1'b0);
      m_s = step(m_s, up_dn, 1'b1);
    end
  end

  // Per-cycle comparison of both instances against the model
  always @(negedge clk) begin
    if (m_valid && cmp_en) begin
      chk("wrap_bin",  bin_w,  m_w);
      chk("wrap_gray", gray_w, to_gray(m_w));
      chk("wrap_tc",   tc_w,   tc_exp(m_w));
      chk("wrap_err",  err_w,  0);
      chk("sat_bin",   bin_s,  m_s);
      chk("sat_gray",  gray_s, to_gray(m_s));
      chk("sat_tc",    tc_s,   tc_exp(m_s));
      chk("sat_err",   err_s,  0);
    end
  end

  // Apply inputs, take one edge, return just after the sampling edge
  task automatic tick(input logic r, input logic e, input logic u,
                      input logic l, input logic [W-1:0] lv);
    rst = r; clk_en = e; up_dn = u; load = l; load_val = lv;
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  int unsigned exp_gray [4] = '{1, 3, 2, 6};

  initial begin
    rst = 1'b1; clk_en = 1'b0; up_dn = 1'b0; load = 1'b0; load_val = '0;
    @(negedge clk);

    // Reset held 4 cycles with a down-count request that would otherwise hit tc
    repeat (4) tick(1, 1, 0, 0, 4'd0);
    chk("rst_gray", gray_w, 0);
    chk("rst_bin",  bin_w,  0);
    chk("rst_tc",   tc_w,   0);

    // Count up from reset
    for (int i = 0; i < 4; i++) begin
      tick(0, 1, 1, 0, 4'd0);
      chk("up_seq_gray", gray_w, exp_gray[i]);
      chk("up_seq_tc",   tc_w,   0);
    end
    repeat (10) tick(0, 1, 1, 0, 4'd0);
    chk("up14_bin", bin_w, 14);
    chk("up14_tc",  tc_w,  0);

    // Up-wrap vs up-saturate at B=15
    tick(0, 1, 1, 0, 4'd0);
    chk("top_gray", gray_w, 4'b1000);
    chk("top_tc",   tc_w,   1);
    tick(0, 1, 1, 0, 4'd0);
    chk("wrap_to_zero", gray_w, 0);
    chk("wrap_err0",    err_w,  0);
    chk("sat_hold_top", gray_s, 4'b1000);
    chk("sat_tc_top",   tc_s,   1);

    // Down-saturate at 0 for 3 enabled edges
    tick(1, 0, 0, 0, 4'd0);
    for (int i = 0; i < 3; i++) begin
      tick(0, 1, 0, 0, 4'd0);
      chk("sat_dn_gray", gray_s, 0);
      chk("sat_dn_tc",   tc_s,   1);
    end
    chk("wrap_dn_bin", bin_w, 13);

    // Load with clk_en high: no extra step
    tick(0, 1, 1, 1, 4'b1010);
    chk("load_bin",  bin_w,  4'b1010);
    chk("load_gray", gray_w, 4'b1111);
    tick(0, 1, 1, 0, 4'd0);
    chk("load_up_gray", gray_w, 4'b1110);

    // Direction change and hold
    tick(0, 0, 0, 1, 4'd4);
    tick(0, 1, 1, 0, 4'd0);
    chk("dir_5a", bin_w, 5);
    tick(0, 1, 0, 0, 4'd0);
    chk("dir_4",  bin_w, 4);
    tick(0, 1, 1, 0, 4'd0);
    chk("dir_5b", bin_w, 5);
    repeat (3) tick(0, 0, 0, 0, 4'd0);
    chk("hold_5", bin_w, 5);

    // Reset mid-count with load asserted too
    tick(1, 1, 1, 1, 4'd9);
    chk("rst_over_load", bin_w, 0);

    // Randomized traffic, with loads biased toward the ends
    for (int i = 0; i < 3000; i++) begin
      int unsigned r;
      int unsigned sel;
      logic [W-1:0] lv;
      r   = $urandom_range(0, 99);
      sel = $urandom_range(0, 3);
      lv  = (sel == 0) ? 4'd0 : (sel == 1) ? 4'd15 : W'($urandom_range(0, MAXV));
      tick(r < 3, $urandom_range(0, 9) < 7, 1'($urandom_range(0, 1)), (r >= 3) && (r < 15), lv);
    end

`ifdef GRAY_STEP_CHECK_EN
    // Illegal Gray jump injected into the state register
    cmp_en = 1'b0;
    tick(1, 0, 0, 0, 4'd0);
    tick(0, 0, 0, 1, 4'd1);
    tick(0, 0, 0, 0, 4'd0);
    chk("chk_pre_err", err_w, 0);
    force u_wrap.r_gray = 4'b0100;
    tick(0, 0, 0, 0, 4'd0);
    release u_wrap.r_gray;
    chk("chk_err_set", err_w, 1);
    repeat (3) tick(0, 1, 1, 0, 4'd0);
    chk("chk_err_sticky", err_w, 1);
    tick(1, 0, 0, 0, 4'd0);
    chk("chk_err_clr", err_w, 0);
    cmp_en = 1'b1;
`endif

    tick(0, 0, 0, 0, 4'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/gray_counter_param.md
GRAY_COUNTER_PARAM -- requirements
Module: gray_counter_param

Interface
REQ-001 The module SHALL have parameter WIDTH, default 4; counter width in bits, legal range 2..16.
REQ-002 The module SHALL have parameter SATURATE, default 0; 0 = wrap at the ends, 1 = hold at the ends.
REQ-003 Port clk SHALL be input, 1 bit; the single clock, with all state updated on its rising edge.
REQ-004 Port rst SHALL be input, 1 bit; synchronous, active-high reset.
REQ-005 Port clk_en SHALL be input, 1 bit; count enable.
REQ-006 Port up_dn SHALL be input, 1 bit; 1 = count up, 0 = count down.
REQ-007 Port load SHALL be input, 1 bit; synchronous load strobe.
REQ-008 Port load_val SHALL be input, WIDTH bits; binary load value.
REQ-009 Port gray_out SHALL be output, WIDTH bits; registered Gray-code count.
REQ-010 Port bin_out SHALL be output, WIDTH bits; registered binary equivalent of gray_out.
REQ-011 Port tc SHALL be output, 1 bit; combinational terminal-count flag.
REQ-012 Port err SHALL be output, 1 bit; registered, sticky Gray-step error flag.

Function
REQ-013 The module SHALL hold a WIDTH-bit binary state B, with bin_out = B and gray_out = B ^ (B >> 1), both registered and updated on the same edge (gray_out never lags bin_out).
REQ-014 Edge priority SHALL be: rst, then load, then count.
REQ-015 load=1 SHALL set B to load_val on the next edge regardless of clk_en and up_dn.
REQ-016 When load=0 and clk_en=1, B SHALL change by exactly one step per edge, +1 if up_dn=1 and -1 if up_dn=0.
REQ-017 When load=0 and clk_en=0, B SHALL hold.
REQ-018 With SATURATE=0, up from 2^WIDTH-1 SHALL wrap to 0 and down from 0 SHALL wrap to 2^WIDTH-1, so gray_out still changes by exactly one bit.
REQ-019 With SATURATE=1, up at 2^WIDTH-1 and down at 0 SHALL hold B unchanged.
REQ-020 tc SHALL be 1 exactly when clk_en=1, load=0, rst=0, and either (up_dn=1 and B=2^WIDTH-1) or (up_dn=0 and B=0); otherwise tc SHALL be 0, in both SATURATE modes.
REQ-021 A change of up_dn SHALL take effect on the same edge it is sampled, with no dead cycle and no double step.
REQ-022 Asserting rst mid-count SHALL abandon the count on that edge, with no partial step.
REQ-023 Asserting load and clk_en together SHALL load the value with no additional step.

Reset
REQ-024 On an edge with rst=1, B SHALL become 0, so gray_out=0 and bin_out=0.
REQ-025 On an edge with rst=1, err SHALL become 0.
REQ-026 rst SHALL override load and clk_en.
REQ-027 tc SHALL be 0 while rst=1.
REQ-028 The module SHALL have no asynchronous reset path.

Configuration
REQ-029 Macro GRAY_STEP_CHECK_EN, when defined, SHALL build a checker that compares gray_out against its previous value on every edge following a pure count or hold edge (no load, no rst).
REQ-030 With GRAY_STEP_CHECK_EN defined, the checker SHALL set err when the Hamming distance between the two values exceeds 1, and err SHALL stay 1 until rst.
REQ-031 With GRAY_STEP_CHECK_EN undefined, err SHALL be tied to 0 and no checker logic SHALL be synthesised; the port list SHALL be identical in both builds.

Verification
REQ-032 The bench SHALL cover reset: WIDTH=4; rst=1 for 4 cycles, then release with clk_en=1 and up_dn=1 -> gray_out = 0000, 0001, 0011, 0010, 0110 ... over 15 edges, tc=0 throughout.
REQ-033 The bench SHALL cover up-wrap: SATURATE=0, up at B=15 -> tc=1 in that cycle, next gray_out=0000 (from 1000), err=0.
REQ-034 The bench SHALL cover down-saturate: SATURATE=1, up_dn=0 at B=0 -> tc=1, gray_out stays 0000 for 3 enabled edges.
REQ-035 The bench SHALL cover load: load=1, load_val=1010, clk_en=1 -> next bin_out=1010 and gray_out=1111; a following up step gives gray_out=1110.
REQ-036 The bench SHALL cover direction change: counting up to B=5, up_dn=0 for one edge then 1 -> bin_out sequence 5, 4, 5; clk_en=0 holds 5.
REQ-037 The bench SHALL cover the error checker: GRAY_STEP_CHECK_EN defined, force the state from 0001 to 0100 without load -> err=1 on the next edge, and err returns to 0 only after rst.
